fft_pingpong_cram: RTL and testbench

//  Double-buffered (ping-pong) complex sample RAM for the FFT datapath; successor to the single-bank dual-port cRAM.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_pingpong_cram_if.sv | 41 ++++
 rtl/cram_bank.sv | 45 ++++
 rtl/fft_pingpong_cram.sv | 127 ++++++++++++
 tb/tb_fft_pingpong_cram.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT ping-pong complex sample RAM.
package fft_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  // Address width for a given depth, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [2*DATA_W_DEF-1:0] cplx_pack(input logic [DATA_W_DEF-1:0] re,
                                                        input logic [DATA_W_DEF-1:0] im);
    return {re, im};
  endfunction

  function automatic void cplx_unpack(input  logic [2*DATA_W_DEF-1:0] w,
                                      output logic [DATA_W_DEF-1:0]   re,
                                      output logic [DATA_W_DEF-1:0]   im);
    re = w[2*DATA_W_DEF-1:DATA_W_DEF];
    im = w[DATA_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/fft_pingpong_cram_if.sv
// Compute, IO and swap/status signals of the ping-pong complex RAM.
interface fft_pingpong_cram_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 20
);
  import fft_pkg::*;
  localparam int unsigned ADDR_W = addr_w(DEPTH);

  logic              c_rd_en;
  logic [ADDR_W-1:0] c_rd_addr1, c_rd_addr2;
  logic              c_rd_valid;
  logic [DATA_W-1:0] c_rd_re1, c_rd_im1, c_rd_re2, c_rd_im2;
  logic              c_wr_en;
  logic [ADDR_W-1:0] c_wr_addr1, c_wr_addr2;
  logic [DATA_W-1:0] c_wr_re1, c_wr_im1, c_wr_re2, c_wr_im2;
  logic              io_wr_en;
  logic [ADDR_W-1:0] io_wr_addr;
  logic [DATA_W-1:0] io_wr_re, io_wr_im;
  logic              io_rd_en;
  logic [ADDR_W-1:0] io_rd_addr;
  logic              io_rd_valid;
  logic [DATA_W-1:0] io_rd_re, io_rd_im;
  logic              swap_req, swap_ack, bank_sel;
  logic              err_range, err_collide;

  modport master (
    output c_rd_en, c_rd_addr1, c_rd_addr2,
    output c_wr_en, c_wr_addr1, c_wr_addr2, c_wr_re1, c_wr_im1, c_wr_re2, c_wr_im2,
    output io_wr_en, io_wr_addr, io_wr_re, io_wr_im, io_rd_en, io_rd_addr, swap_req,
    input  c_rd_valid, c_rd_re1, c_rd_im1, c_rd_re2, c_rd_im2,
    input  io_rd_valid, io_rd_re, io_rd_im, swap_ack, bank_sel, err_range, err_collide
  );

  modport slave (
    input  c_rd_en, c_rd_addr1, c_rd_addr2,
    input  c_wr_en, c_wr_addr1, c_wr_addr2, c_wr_re1, c_wr_im1, c_wr_re2, c_wr_im2,
    input  io_wr_en, io_wr_addr, io_wr_re, io_wr_im, io_rd_en, io_rd_addr, swap_req,
    output c_rd_valid, c_rd_re1, c_rd_im1, c_rd_re2, c_rd_im2,
    output io_rd_valid, io_rd_re, io_rd_im, swap_ack, bank_sel, err_range, err_collide
  );
endinterface

// File: rtl/cram_bank.sv
// One RAM bank: two write ports (port 2 wins on equal address) and two
// registered read-first read ports; out-of-range accesses are ignored / read as 0.
module cram_bank #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 20,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [WORD_W-1:0] wd1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] wa2,
  input  logic [WORD_W-1:0] wd2,
  input  logic              re1,
  input  logic [ADDR_W-1:0] ra1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WORD_W-1:0] rd1,
  output logic [WORD_W-1:0] rd2
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];

  function automatic logic ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  always_ff @(posedge clk) begin
    if (we1 && ok(wa1)) mem[wa1] <= wd1;
    if (we2 && ok(wa2)) mem[wa2] <= wd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1 <= '0;
      rd2 <= '0;
    end else begin
      if (re1) rd1 <= ok(ra1) ? mem[ra1] : '0;
      if (re2) rd2 <= ok(ra2) ? mem[ra2] : '0;
    end
  end
endmodule

// File: rtl/fft_pingpong_cram.sv
// Ping-pong complex sample RAM: compute bank (2R/2W) and IO bank (1R/1W),
// exchanged by a swap handshake, with sticky range and collision flags.
module fft_pingpong_cram
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 20
) (
  input logic               clk,
  input logic               rst,
  fft_pingpong_cram_if.slave bus
);
  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned WORD_W = 2 * DATA_W;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;

  logic  bank_sel, bank_sel_q, swap_ack;
  logic  c_valid, io_valid, err_range, err_collide;
  word_t c_hold1, c_hold2, io_hold;
  word_t c_word1, c_word2, io_word;
  logic  range_hit;

  logic  we1 [2], we2 [2], re1 [2], re2 [2];
  addr_t wa1 [2], wa2 [2], ra1 [2], ra2 [2];
  word_t wd1 [2], wd2 [2], rd1 [2], rd2 [2];

  function automatic logic ok(input addr_t a);
    return {1'b0, a} < LIMIT;
  endfunction

  // Bank b holds the compute role when bank_sel == b.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      if (1'(b) == bank_sel) begin
        we1[b] = bus.c_wr_en && !rst;
        wa1[b] = bus.c_wr_addr1;
        wd1[b] = {bus.c_wr_re1, bus.c_wr_im1};
        we2[b] = bus.c_wr_en && !rst;
        wa2[b] = bus.c_wr_addr2;
        wd2[b] = {bus.c_wr_re2, bus.c_wr_im2};
        re1[b] = bus.c_rd_en;
        ra1[b] = bus.c_rd_addr1;
        re2[b] = bus.c_rd_en;
        ra2[b] = bus.c_rd_addr2;
      end else begin
        we1[b] = bus.io_wr_en && !rst;
        wa1[b] = bus.io_wr_addr;
        wd1[b] = {bus.io_wr_re, bus.io_wr_im};
        we2[b] = 1'b0;
        wa2[b] = bus.io_wr_addr;
        wd2[b] = '0;
        re1[b] = bus.io_rd_en;
        ra1[b] = bus.io_rd_addr;
        re2[b] = 1'b0;
        ra2[b] = bus.io_rd_addr;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    cram_bank #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
      .clk(clk), .rst(rst),
      .we1(we1[gi]), .wa1(wa1[gi]), .wd1(wd1[gi]),
      .we2(we2[gi]), .wa2(wa2[gi]), .wd2(wd2[gi]),
      .re1(re1[gi]), .ra1(ra1[gi]), .rd1(rd1[gi]),
      .re2(re2[gi]), .ra2(ra2[gi]), .rd2(rd2[gi])
    );
  end

  always_comb begin
    range_hit = (bus.c_rd_en  && (!ok(bus.c_rd_addr1) || !ok(bus.c_rd_addr2)))
             || (bus.c_wr_en  && (!ok(bus.c_wr_addr1) || !ok(bus.c_wr_addr2)))
             || (bus.io_wr_en && !ok(bus.io_wr_addr))
             || (bus.io_rd_en && !ok(bus.io_rd_addr));
  end

  // Read data comes from the bank that held each role at the sampling edge;
  // hold registers keep outputs stable afterwards, even across a swap.
  always_comb begin
    c_word1 = bank_sel_q ? rd1[1] : rd1[0];
    c_word2 = bank_sel_q ? rd2[1] : rd2[0];
    io_word = bank_sel_q ? rd1[0] : rd1[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel    <= 1'b0;
      bank_sel_q  <= 1'b0;
      swap_ack    <= 1'b0;
      c_valid     <= 1'b0;
      io_valid    <= 1'b0;
      c_hold1     <= '0;
      c_hold2     <= '0;
      io_hold     <= '0;
      err_range   <= 1'b0;
      err_collide <= 1'b0;
    end else begin
      bank_sel    <= bank_sel ^ bus.swap_req;
      bank_sel_q  <= bank_sel;
      swap_ack    <= bus.swap_req;
      c_valid     <= bus.c_rd_en;
      io_valid    <= bus.io_rd_en;
      if (c_valid) begin
        c_hold1 <= c_word1;
        c_hold2 <= c_word2;
      end
      if (io_valid) io_hold <= io_word;
      err_range   <= err_range | range_hit;
      err_collide <= err_collide | (bus.c_wr_en && (bus.c_wr_addr1 == bus.c_wr_addr2));
    end
  end

  always_comb begin
    {bus.c_rd_re1, bus.c_rd_im1} = c_valid  ? c_word1 : c_hold1;
    {bus.c_rd_re2, bus.c_rd_im2} = c_valid  ? c_word2 : c_hold2;
    {bus.io_rd_re, bus.io_rd_im} = io_valid ? io_word : io_hold;
    bus.c_rd_valid  = c_valid;
    bus.io_rd_valid = io_valid;
    bus.swap_ack    = swap_ack;
    bus.bank_sel    = bank_sel;
    bus.err_range   = err_range;
    bus.err_collide = err_collide;
  end
endmodule

// File: tb/tb_fft_pingpong_cram.sv
// Directed, table-driven bench for fft_pingpong_cram (DATA_W=16, DEPTH=20).
module tb_fft_pingpong_cram;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fft_pingpong_cram_if #(.DATA_W(16), .DEPTH(20)) bus ();

  fft_pingpong_cram #(.DATA_W(16), .DEPTH(20)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic cr; logic [4:0] cra1, cra2;
    logic cw; logic [4:0] cwa1, cwa2;
    logic [15:0] w1re, w1im, w2re, w2im;
    logic iw; logic [4:0] iwa; logic [15:0] iwre, iwim;
    logic ir; logic [4:0] ira;
    logic sw;
  } stim_t;

  typedef struct {
    logic cv; logic [15:0] c1re, c1im, c2re, c2im;
    logic iv; logic [15:0] ire, iim;
    logic ack, sel, erng, ecol;
  } exp_t;

  typedef struct { stim_t s; exp_t e; } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    bus.c_rd_en    = s.cr;  bus.c_rd_addr1 = s.cra1; bus.c_rd_addr2 = s.cra2;
    bus.c_wr_en    = s.cw;  bus.c_wr_addr1 = s.cwa1; bus.c_wr_addr2 = s.cwa2;
    bus.c_wr_re1   = s.w1re; bus.c_wr_im1 = s.w1im;
    bus.c_wr_re2   = s.w2re; bus.c_wr_im2 = s.w2im;
    bus.io_wr_en   = s.iw;  bus.io_wr_addr = s.iwa;
    bus.io_wr_re   = s.iwre; bus.io_wr_im = s.iwim;
    bus.io_rd_en   = s.ir;  bus.io_rd_addr = s.ira;
    bus.swap_req   = s.sw;
  endtask

  function automatic stim_t idle();
    return '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 16'h0, 16'h0, 16'h0, 16'h0,
             1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 5'd0, 1'b0};
  endfunction

  function automatic stim_t junk();
    return '{1'b1, 5'd2, 5'd25, 1'b1, 5'd2, 5'd2, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D,
             1'b1, 5'd2, 16'hABCD, 16'hEF01, 1'b1, 5'd25, 1'b1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".c_valid"},  32'(bus.c_rd_valid),  32'(e.cv));
    chk({tag, ".c_re1"},    32'(bus.c_rd_re1),    32'(e.c1re));
    chk({tag, ".c_im1"},    32'(bus.c_rd_im1),    32'(e.c1im));
    chk({tag, ".c_re2"},    32'(bus.c_rd_re2),    32'(e.c2re));
    chk({tag, ".c_im2"},    32'(bus.c_rd_im2),    32'(e.c2im));
    chk({tag, ".io_valid"}, 32'(bus.io_rd_valid), 32'(e.iv));
    chk({tag, ".io_re"},    32'(bus.io_rd_re),    32'(e.ire));
    chk({tag, ".io_im"},    32'(bus.io_rd_im),    32'(e.iim));
    chk({tag, ".swap_ack"}, 32'(bus.swap_ack),    32'(e.ack));
    chk({tag, ".bank_sel"}, 32'(bus.bank_sel),    32'(e.sel));
    chk({tag, ".err_rng"},  32'(bus.err_range),   32'(e.erng));
    chk({tag, ".err_col"},  32'(bus.err_collide), 32'(e.ecol));
  endtask

  initial begin
    stim_t s;
    exp_t  zero_e;
    int    acks;

    zero_e = '{1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Fields: cr,cra1,cra2, cw,cwa1,cwa2, w1re,w1im,w2re,w2im, iw,iwa,iwre,iwim, ir,ira, sw
    //         cv,c1re,c1im,c2re,c2im, iv,ire,iim, ack,sel,erng,ecol
    vecs[0]  = '{'{1, 2, 2, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 2, 0},
                 '{1, 16'h3333, 16'h4444, 16'h3333, 16'h4444, 1, 16'h1111, 16'h2222, 0, 0, 0, 0}};
    vecs[1]  = '{'{0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 3, 16'h1234, 16'h5678, 0, 0, 0},
                 '{0, 16'h3333, 16'h4444, 16'h3333, 16'h4444, 0, 16'h1111, 16'h2222, 0, 0, 0, 0}};
    vecs[2]  = '{'{0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 5, 16'h5555, 16'h6666, 0, 0, 0},
                 '{0, 16'h3333, 16'h4444, 16'h3333, 16'h4444, 0, 16'h1111, 16'h2222, 0, 0, 0, 0}};
    vecs[3]  = '{'{0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1},
                 '{0, 16'h3333, 16'h4444, 16'h3333, 16'h4444, 0, 16'h1111, 16'h2222, 1, 1, 0, 0}};
    vecs[4]  = '{'{1, 3, 2, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 2, 0},
                 '{1, 16'h1234, 16'h5678, 16'h1111, 16'h2222, 1, 16'h3333, 16'h4444, 0, 1, 0, 0}};
    vecs[5]  = '{'{1, 5, 3, 1, 5, 6, 16'h00AA, 16'h00BB, 16'h0C0C, 16'h0D0D, 0, 0, 16'h0, 16'h0, 0, 0, 0},
                 '{1, 16'h5555, 16'h6666, 16'h1234, 16'h5678, 0, 16'h3333, 16'h4444, 0, 1, 0, 0}};
    vecs[6]  = '{'{1, 5, 6, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0},
                 '{1, 16'h00AA, 16'h00BB, 16'h0C0C, 16'h0D0D, 0, 16'h3333, 16'h4444, 0, 1, 0, 0}};
    vecs[7]  = '{'{0, 0, 0, 1, 7, 7, 16'h1, 16'h1, 16'h2, 16'h2, 0, 0, 16'h0, 16'h0, 0, 0, 0},
                 '{0, 16'h00AA, 16'h00BB, 16'h0C0C, 16'h0D0D, 0, 16'h3333, 16'h4444, 0, 1, 0, 1}};
    vecs[8]  = '{'{1, 7, 7, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0},
                 '{1, 16'h2, 16'h2, 16'h2, 16'h2, 0, 16'h3333, 16'h4444, 0, 1, 0, 1}};
    vecs[9]  = '{'{1, 3, 5, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 2, 1},
                 '{1, 16'h1234, 16'h5678, 16'h00AA, 16'h00BB, 1, 16'h3333, 16'h4444, 1, 0, 0, 1}};
    vecs[10] = '{'{1, 2, 2, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 3, 0},
                 '{1, 16'h3333, 16'h4444, 16'h3333, 16'h4444, 1, 16'h1234, 16'h5678, 0, 0, 0, 1}};

    // Reset with every input active: nothing may leak through.
    rst = 1'b1;
    drive(junk());
    step();
    check_all("rst0", zero_e);

    // Seed address 2 of both banks, then reset again over junk writes to it.
    rst = 1'b0;
    s = idle();
    s.cw = 1'b1; s.cwa1 = 5'd2; s.w1re = 16'h3333; s.w1im = 16'h4444; s.cwa2 = 5'd9;
    s.iw = 1'b1; s.iwa = 5'd2; s.iwre = 16'h1111; s.iwim = 16'h2222;
    drive(s);
    step();
    rst = 1'b1;
    drive(junk());
    step();
    check_all("rst1", zero_e);
    chk("rst1.pack", {bus.c_rd_re1, bus.c_rd_im1}, cplx_pack(16'h0, 16'h0));
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].s);
      step();
      check_all($sformatf("v%0d", i), vecs[i].e);
    end

    // Out-of-range: lane 1 write to 31 suppressed, lane 2 still lands; IO read of 25 gives 0.
    s = idle();
    s.cw = 1'b1; s.cwa1 = 5'd11; s.cwa2 = 5'd15;
    s.w1re = 16'hB1B1; s.w1im = 16'hB2B2; s.w2re = 16'hF1F1; s.w2im = 16'hF2F2;
    drive(s);
    step();
    chk("rng.pre_err", 32'(bus.err_range), 32'd0);
    s = idle();
    s.cw = 1'b1; s.cwa1 = 5'd31; s.cwa2 = 5'd8;
    s.w1re = 16'hDEAD; s.w1im = 16'hDEAD; s.w2re = 16'h0808; s.w2im = 16'h0909;
    s.ir = 1'b1; s.ira = 5'd25;
    drive(s);
    step();
    chk("rng.io_valid", 32'(bus.io_rd_valid), 32'd1);
    chk("rng.io_re", 32'(bus.io_rd_re), 32'h0);
    chk("rng.io_im", 32'(bus.io_rd_im), 32'h0);
    chk("rng.err", 32'(bus.err_range), 32'd1);
    s = idle();
    s.cr = 1'b1; s.cra1 = 5'd11; s.cra2 = 5'd15;
    drive(s);
    step();
    chk("rng.a11", {bus.c_rd_re1, bus.c_rd_im1}, 32'hB1B1B2B2);
    chk("rng.a15", {bus.c_rd_re2, bus.c_rd_im2}, 32'hF1F1F2F2);
    s = idle();
    s.cr = 1'b1; s.cra1 = 5'd8; s.cra2 = 5'd31;
    drive(s);
    step();
    chk("rng.a8", {bus.c_rd_re1, bus.c_rd_im1}, 32'h08080909);
    chk("rng.a31", {bus.c_rd_re2, bus.c_rd_im2}, 32'h0);
    chk("rng.c_valid", 32'(bus.c_rd_valid), 32'd1);

    // Back-to-back swaps return to bank_sel=0 with one ack per request.
    acks = 0;
    s = idle();
    s.sw = 1'b1;
    drive(s);
    step();
    chk("swap1.sel", 32'(bus.bank_sel), 32'd1);
    acks += int'(bus.swap_ack);
    step();
    chk("swap2.sel", 32'(bus.bank_sel), 32'd0);
    acks += int'(bus.swap_ack);
    drive(idle());
    step();
    acks += int'(bus.swap_ack);
    chk("swap3.ack", 32'(bus.swap_ack), 32'd0);
    chk("swap3.sel", 32'(bus.bank_sel), 32'd0);
    chk("swap.acks", 32'(acks), 32'd2);
    chk("sticky.col", 32'(bus.err_collide), 32'd1);
    chk("sticky.rng", 32'(bus.err_range), 32'd1);

    // Only reset clears the sticky flags.
    rst = 1'b1;
    step();
    check_all("rst2", zero_e);
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
